als_responder: RTL and testbench

Synchronous SPI responder that emulates the ambient-light-sensor ADC on the ALS_CS/ALS_SCK/ALS_SDO interface. It lets the ALS reader be exercised on-board or in loopback without the physical sensor. Holds an 8-bit sample loaded from fabric and serialises it in the sensor's 16-bit frame format whenever the master asserts chip select. Sits opposite the ALS reader, driven by the top-level clock.

---
 rtl/als_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_als_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/als_responder.sv
// ---------------------------------------------------------------------------
// als_responder
//
// Emulates the ambient-light-sensor ADC on its SPI-like pins so the ALS
// reader can be exercised without the physical sensor. An 8-bit sample
// loaded from fabric is reported in the sensor's frame format:
// LEAD_BITS zeros, the sample MSB first, then TRAIL_BITS zeros.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-high reset
//   sample       in   value reported by the emulated sensor
//   sample_load  in   single-cycle strobe, captures sample into the shadow
//   ALS_CS       in   chip select from master, active low, asynchronous
//   ALS_SCK      in   serial clock from master, idles high, asynchronous
//   ALS_SDO      out  registered serial data to master
//   busy         out  high while a frame is in progress
//   frame_done   out  one-cycle pulse, CS released after the full frame
//   frame_abort  out  one-cycle pulse, CS released before the full frame
//
// Optional feature: define ALS_RESP_SWEEP_EN to make the shadow register
// increment on every completed frame (ramp pattern for soak tests).
// ---------------------------------------------------------------------------
module als_responder #(
    parameter int LEAD_BITS  = 4,
    parameter int DATA_BITS  = 8,
    parameter int TRAIL_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] sample,
    input  logic                 sample_load,
    input  logic                 ALS_CS,
    input  logic                 ALS_SCK,
    output logic                 ALS_SDO,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort
);

    localparam int N     = LEAD_BITS + DATA_BITS + TRAIL_BITS;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Synchroniser + edge-detect flops
    logic r_cs_s1, r_cs_s2, r_cs_s3;
    logic r_sck_s1, r_sck_s2, r_sck_s3;

    // Arming logic: keeps a CS already low at reset release from looking
    // like a fresh falling edge once the synchroniser refills.
    logic [1:0] r_settle;
    logic       r_armed;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_BITS-1:0]  r_shadow;
    logic [N-1:0]          r_frame;
    logic [N-1:0]          w_frame_nxt;
    logic [N-1:0]          w_frame_load;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_sdo;
    logic                  w_sdo_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_abort;
    logic                  w_abort_nxt;

    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck_fall;

    // Flops reset to the idle level (high) so reset itself never makes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_s1  <= 1'b1;
            r_cs_s2  <= 1'b1;
            r_cs_s3  <= 1'b1;
            r_sck_s1 <= 1'b1;
            r_sck_s2 <= 1'b1;
            r_sck_s3 <= 1'b1;
        end else begin
            r_cs_s1  <= ALS_CS;
            r_cs_s2  <= r_cs_s1;
            r_cs_s3  <= r_cs_s2;
            r_sck_s1 <= ALS_SCK;
            r_sck_s2 <= r_sck_s1;
            r_sck_s3 <= r_sck_s2;
        end
    end

    // After two cycles r_cs_s2 carries the real pin level; arm only once it
    // has been seen high, so a frame needs a genuine high-to-low transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end
            if (r_settle == 2'd2 && r_cs_s2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_cs_fall  = r_armed & r_cs_s3 & ~r_cs_s2;
    assign w_cs_rise  = ~r_cs_s3 & r_cs_s2;
    assign w_sck_fall = r_sck_s3 & ~r_sck_s2;

    assign w_frame_load = {{LEAD_BITS{1'b0}}, r_shadow, {TRAIL_BITS{1'b0}}};

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic. CS edges always take priority over SCK edges.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sck_fall && r_cnt == CNT_W'(N)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: output / datapath next-value logic
    always_comb begin
        w_frame_nxt = r_frame;
        w_cnt_nxt   = r_cnt;
        w_sdo_nxt   = r_sdo;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_sdo_nxt = 1'b0;
                if (w_cs_fall) begin
                    w_frame_nxt = w_frame_load;
                    w_sdo_nxt   = w_frame_load[N-1];
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (w_cs_rise) begin
                    w_abort_nxt = 1'b1;
                    w_sdo_nxt   = 1'b0;
                end else if (w_sck_fall) begin
                    if (r_cnt == CNT_W'(N)) begin
                        // All N bits presented: this fall ends the frame.
                        w_sdo_nxt = 1'b0;
                    end else begin
                        w_frame_nxt = r_frame << 1;
                        w_sdo_nxt   = r_frame[N-2];
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_sdo_nxt = 1'b0;
                if (w_cs_rise) begin
                    w_done_nxt = 1'b1;
                end
            end
            default: begin
                w_sdo_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame <= '0;
            r_cnt   <= '0;
            r_sdo   <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_frame <= w_frame_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sdo   <= w_sdo_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    // Shadow register. A frame capture in the same cycle as a load sees the
    // old value because the frame is built from the registered shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (sample_load) begin
            r_shadow <= sample;
`ifdef ALS_RESP_SWEEP_EN
        end else if (w_done_nxt) begin
            r_shadow <= r_shadow + DATA_BITS'(1);
`endif
        end
    end

    assign ALS_SDO     = r_sdo;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;

endmodule

// File: tb/tb_als_responder.sv
module tb_als_responder;

    localparam int PH = 10;
`ifdef ALS_RESP_SWEEP_EN
    localparam int SWEEP = 1;
`else
    localparam int SWEEP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sample;
    logic       sample_load;
    logic       ALS_CS;
    logic       ALS_SCK;
    logic       ALS_SDO;
    logic       busy;
    logic       frame_done;
    logic       frame_abort;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done_seen  = 0;
    int n_abort_seen = 0;

    als_responder #(
        .LEAD_BITS (4),
        .DATA_BITS (8),
        .TRAIL_BITS(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample     (sample),
        .sample_load(sample_load),
        .ALS_CS     (ALS_CS),
        .ALS_SCK    (ALS_SCK),
        .ALS_SDO    (ALS_SDO),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done)  n_done_seen  <= n_done_seen + 1;
        if (frame_abort) n_abort_seen <= n_abort_seen + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_sample(input logic [7:0] v);
        @(negedge clk);
        sample      = v;
        sample_load = 1'b1;
        @(negedge clk);
        sample_load = 1'b0;
    endtask

    task automatic cs_drop();
        ALS_CS = 1'b0;
        wait_clk(PH);
    endtask

    task automatic cs_release();
        ALS_CS = 1'b1;
        wait_clk(PH);
    endtask

    // Master samples each bit during the high phase, just before the fall
    // that advances to the next bit.
    task automatic shift_bits(input int n, output logic [31:0] cap,
                              output logic busy_all, output logic busy_any);
        cap      = '0;
        busy_all = 1'b1;
        busy_any = 1'b0;
        for (int i = 0; i < n; i++) begin
            cap = {cap[30:0], ALS_SDO};
            if (busy !== 1'b1) busy_all = 1'b0;
            if (busy === 1'b1) busy_any = 1'b1;
            ALS_SCK = 1'b0;
            wait_clk(PH);
            ALS_SCK = 1'b1;
            wait_clk(PH);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sample = 8'h00; sample_load = 1'b0;
        ALS_CS = 1'b1; ALS_SCK = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(5);
        n_checks++; if (ALS_SDO !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b expected 0", ALS_SDO); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        n_checks++; if (frame_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b expected 0", frame_abort); end
    endtask

    task automatic test_full_frame();
        logic [31:0] cap; logic ball, bany; int d0, a0;
        load_sample(8'hA5);
        d0 = n_done_seen; a0 = n_abort_seen;
        cs_drop();
        shift_bits(16, cap, ball, bany);
        n_checks++; if (cap !== 32'h0A50) begin n_fail++; $display("FAIL full_data: got %h expected %h", cap, 32'h0A50); end
        n_checks++; if (ball !== 1'b1) begin n_fail++; $display("FAIL full_busy_during: got %b expected 1", ball); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_done_state: got %b expected 1", busy); end
        n_checks++; if (ALS_SDO !== 1'b0) begin n_fail++; $display("FAIL full_sdo_done_state: got %b expected 0", ALS_SDO); end
        cs_release();
        n_checks++; if (n_done_seen - d0 !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", n_done_seen - d0); end
        n_checks++; if (n_abort_seen - a0 !== 0) begin n_fail++; $display("FAIL full_abort_count: got %0d expected 0", n_abort_seen - a0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_midframe_load();
        logic [31:0] c1, c2, cap, exp2; logic ball, bany; logic [7:0] e;
        load_sample(8'hA5);
        cs_drop();
        shift_bits(6, c1, ball, bany);
        load_sample(8'h3C);
        shift_bits(10, c2, ball, bany);
        cs_release();
        cap = (c1 << 10) | c2;
        n_checks++; if (cap !== 32'h0A50) begin n_fail++; $display("FAIL midload_current: got %h expected %h", cap, 32'h0A50); end
        e = 8'h3C + 8'(SWEEP);
        exp2 = {20'h0, e, 4'h0};
        cs_drop();
        shift_bits(16, cap, ball, bany);
        cs_release();
        n_checks++; if (cap !== exp2) begin n_fail++; $display("FAIL midload_next: got %h expected %h", cap, exp2); end
    endtask

    task automatic test_abort();
        logic [31:0] cap; logic ball, bany; int d0, a0;
        load_sample(8'h3C);
        d0 = n_done_seen; a0 = n_abort_seen;
        cs_drop();
        shift_bits(7, cap, ball, bany);
        n_checks++; if (cap !== 32'h1) begin n_fail++; $display("FAIL abort_partial: got %h expected %h", cap, 32'h1); end
        cs_release();
        n_checks++; if (n_abort_seen - a0 !== 1) begin n_fail++; $display("FAIL abort_count: got %0d expected 1", n_abort_seen - a0); end
        n_checks++; if (n_done_seen - d0 !== 0) begin n_fail++; $display("FAIL abort_done_count: got %0d expected 0", n_done_seen - d0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        d0 = n_done_seen;
        cs_drop();
        shift_bits(16, cap, ball, bany);
        cs_release();
        n_checks++; if (cap !== 32'h03C0) begin n_fail++; $display("FAIL abort_next_frame: got %h expected %h", cap, 32'h03C0); end
        n_checks++; if (n_done_seen - d0 !== 1) begin n_fail++; $display("FAIL abort_next_done: got %0d expected 1", n_done_seen - d0); end
    endtask

    task automatic test_overrun();
        logic [31:0] cap; logic ball, bany; int d0;
        load_sample(8'h81);
        d0 = n_done_seen;
        cs_drop();
        shift_bits(20, cap, ball, bany);
        n_checks++; if (cap !== 32'h08100) begin n_fail++; $display("FAIL overrun_data: got %h expected %h", cap, 32'h08100); end
        n_checks++; if (ball !== 1'b1) begin n_fail++; $display("FAIL overrun_busy: got %b expected 1", ball); end
        cs_release();
        n_checks++; if (n_done_seen - d0 !== 1) begin n_fail++; $display("FAIL overrun_done_count: got %0d expected 1", n_done_seen - d0); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] cap; logic ball, bany; int d0, a0;
        load_sample(8'h5A);
        cs_drop();
        shift_bits(5, cap, ball, bany);
        reset = 1'b1;
        wait_clk(2);
        n_checks++; if (ALS_SDO !== 1'b0) begin n_fail++; $display("FAIL rstmid_sdo: got %b expected 0", ALS_SDO); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        reset = 1'b0;
        wait_clk(5);
        d0 = n_done_seen; a0 = n_abort_seen;
        shift_bits(4, cap, ball, bany);
        n_checks++; if (cap !== 32'h0) begin n_fail++; $display("FAIL rstmid_no_data: got %h expected 0", cap); end
        n_checks++; if (bany !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_busy: got %b expected 0", bany); end
        cs_release();
        n_checks++; if (n_done_seen - d0 !== 0) begin n_fail++; $display("FAIL rstmid_done: got %0d expected 0", n_done_seen - d0); end
        n_checks++; if (n_abort_seen - a0 !== 0) begin n_fail++; $display("FAIL rstmid_abort: got %0d expected 0", n_abort_seen - a0); end
        load_sample(8'h5A);
        cs_drop();
        shift_bits(16, cap, ball, bany);
        cs_release();
        n_checks++; if (cap !== 32'h05A0) begin n_fail++; $display("FAIL rstmid_next_frame: got %h expected %h", cap, 32'h05A0); end
    endtask

    task automatic test_sweep();
        logic [31:0] cap; logic ball, bany;
        logic [31:0] exp_tab [3];
`ifdef ALS_RESP_SWEEP_EN
        exp_tab[0] = 32'h0FE0; exp_tab[1] = 32'h0FF0; exp_tab[2] = 32'h0000;
`else
        exp_tab[0] = 32'h0FE0; exp_tab[1] = 32'h0FE0; exp_tab[2] = 32'h0FE0;
`endif
        load_sample(8'hFE);
        for (int f = 0; f < 3; f++) begin
            cs_drop();
            shift_bits(16, cap, ball, bany);
            cs_release();
            n_checks++; if (cap !== exp_tab[f]) begin n_fail++; $display("FAIL sweep_frame%0d: got %h expected %h", f, cap, exp_tab[f]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_midframe_load();
        test_abort();
        test_overrun();
        test_reset_midframe();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
